alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_pkg.sv | 32 +++
 rtl/alu_op_sequencer_op_class_decode.sv | 25 ++
 rtl/alu_op_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and opcode constants for the ALU instruction sequencer.
// State encoding is fixed so that the debug state output stays stable.
package alu_op_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    IMM,
    MOVE,
    MULDIV,
    ILLEGAL
  } op_class_t;

  localparam logic [4:0] OP_ADDI = 5'b00011;
  localparam logic [4:0] OP_ANDI = 5'b01011;
  localparam logic [4:0] OP_ORI  = 5'b01010;
  localparam logic [4:0] OP_MFHI = 5'b10000;
  localparam logic [4:0] OP_MFLO = 5'b10001;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;

endpackage

// File: rtl/alu_op_sequencer_op_class_decode.sv
// Combinational opcode-to-instruction-class mapping used by the execute phase.
module op_class_decode
  import alu_op_sequencer_pkg::*;
#(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] OP_ADDI = OPW'(5'b00011),
  parameter logic [OPW-1:0] OP_ANDI = OPW'(5'b01011),
  parameter logic [OPW-1:0] OP_ORI  = OPW'(5'b01010),
  parameter logic [OPW-1:0] OP_MFHI = OPW'(5'b10000),
  parameter logic [OPW-1:0] OP_MFLO = OPW'(5'b10001),
  parameter logic [OPW-1:0] OP_MUL  = OPW'(5'b01110),
  parameter logic [OPW-1:0] OP_DIV  = OPW'(5'b01111)
) (
  input  logic [OPW-1:0] op,
  output op_class_t      op_class
);

  always_comb begin
    op_class = ILLEGAL;
    if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) op_class = IMM;
    else if (op == OP_MFHI || op == OP_MFLO)             op_class = MOVE;
    else if (op == OP_MUL || op == OP_DIV)               op_class = MULDIV;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Moore control sequencer: fetch (T0-T2) then class-specific execute (T3-T6).
// Handshake: run=1 in IDLE or the last execute cycle starts a fetch; T1 waits for Mem_ready=1.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int             OPW         = 5,
  parameter int             MEM_TIMEOUT = 8,
  parameter logic [OPW-1:0] OP_ADDI     = OPW'(alu_op_sequencer_pkg::OP_ADDI),
  parameter logic [OPW-1:0] OP_ANDI     = OPW'(alu_op_sequencer_pkg::OP_ANDI),
  parameter logic [OPW-1:0] OP_ORI      = OPW'(alu_op_sequencer_pkg::OP_ORI),
  parameter logic [OPW-1:0] OP_MFHI     = OPW'(alu_op_sequencer_pkg::OP_MFHI),
  parameter logic [OPW-1:0] OP_MFLO     = OPW'(alu_op_sequencer_pkg::OP_MFLO),
  parameter logic [OPW-1:0] OP_MUL      = OPW'(alu_op_sequencer_pkg::OP_MUL),
  parameter logic [OPW-1:0] OP_DIV      = OPW'(alu_op_sequencer_pkg::OP_DIV)
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic           run,
  input  logic [OPW-1:0] IR_op,
  input  logic           Mem_ready,
  output logic           PCout,
  output logic           IncPC,
  output logic           MARin,
  output logic           Zin,
  output logic           Zlo_out,
  output logic           Zhi_out,
  output logic           PCin,
  output logic           MDRin,
  output logic           Mem_Read,
  output logic           Mem_enable512x32,
  output logic           MDRout,
  output logic           IRin,
  output logic           Grb,
  output logic           Grc,
  output logic           Gra,
  output logic           Rout,
  output logic           Rin,
  output logic           Yin,
  output logic           Cout,
  output logic           HIout,
  output logic           LOout,
  output logic           HIin,
  output logic           LOin,
  output logic [OPW-1:0] opcode,
  output logic           instr_done,
  output logic           fault,
  output logic [3:0]     state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic [CW-1:0]  wait_cnt;
  logic           fault_q;
  op_class_t      op_class;

  op_class_decode #(
    .OPW(OPW), .OP_ADDI(OP_ADDI), .OP_ANDI(OP_ANDI), .OP_ORI(OP_ORI),
    .OP_MFHI(OP_MFHI), .OP_MFLO(OP_MFLO), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)
  ) u_decode (
    .op       (op_q),
    .op_class (op_class)
  );

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == T2) op_q <= IR_op;
      // Counts consecutive not-ready T1 cycles; zero also marks the first T1 cycle.
      if (state_q == T1 && !Mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                             wait_cnt <= '0;
      if (state_d == HALT) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    PCout            = 1'b0;
    IncPC            = 1'b0;
    MARin            = 1'b0;
    Zin              = 1'b0;
    Zlo_out          = 1'b0;
    Zhi_out          = 1'b0;
    PCin             = 1'b0;
    MDRin            = 1'b0;
    Mem_Read         = 1'b0;
    Mem_enable512x32 = 1'b0;
    MDRout           = 1'b0;
    IRin             = 1'b0;
    Grb              = 1'b0;
    Grc              = 1'b0;
    Gra              = 1'b0;
    Rout             = 1'b0;
    Rin              = 1'b0;
    Yin              = 1'b0;
    Cout             = 1'b0;
    HIout            = 1'b0;
    LOout            = 1'b0;
    HIin             = 1'b0;
    LOin             = 1'b0;
    opcode           = '0;
    instr_done       = 1'b0;
    case (state_q)
      IDLE: if (run) state_d = T0;
      T0: begin
        PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1;
        state_d = T1;
      end
      T1: begin
        Zlo_out = 1'b1; MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        PCin = (wait_cnt == '0);
        if (Mem_ready)                              state_d = T2;
        else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) state_d = HALT;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = T3;
      end
      T3: begin
        case (op_class)
          IMM:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = T4; end
          MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = T4; end
          MOVE: begin
            HIout = (op_q == OP_MFHI);
            LOout = (op_q != OP_MFHI);
            Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
          end
          default: state_d = HALT;
        endcase
      end
      T4: begin
        opcode = op_q; Zin = 1'b1;
        if (op_class == IMM) Cout = 1'b1;
        else begin Grb = 1'b1; Rout = 1'b1; end
        state_d = T5;
      end
      T5: begin
        Zlo_out = 1'b1;
        if (op_class == IMM) begin Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
        else begin LOin = 1'b1; state_d = T6; end
      end
      T6: begin
        Zhi_out = 1'b1; HIin = 1'b1; instr_done = 1'b1;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (instr_done) state_d = run ? T0 : IDLE;
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: a per-cycle expected trace is built from the instruction rules.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int W = 34;

  logic Clock = 1'b0;
  logic clear, run, Mem_ready;
  logic [4:0] IR_op;
  logic PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, MDRin, Mem_Read, Mem_enable512x32;
  logic MDRout, IRin, Grb, Grc, Gra, Rout, Rin, Yin, Cout, HIout, LOout, HIin, LOin;
  logic [4:0] opcode;
  logic instr_done, fault;
  logic [3:0] state;

  always #5 Clock = ~Clock;

  alu_op_sequencer dut (
    .Clock(Clock), .clear(clear), .run(run), .IR_op(IR_op), .Mem_ready(Mem_ready),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlo_out(Zlo_out),
    .Zhi_out(Zhi_out), .PCin(PCin), .MDRin(MDRin), .Mem_Read(Mem_Read),
    .Mem_enable512x32(Mem_enable512x32), .MDRout(MDRout), .IRin(IRin), .Grb(Grb),
    .Grc(Grc), .Gra(Gra), .Rout(Rout), .Rin(Rin), .Yin(Yin), .Cout(Cout),
    .HIout(HIout), .LOout(LOout), .HIin(HIin), .LOin(LOin), .opcode(opcode),
    .instr_done(instr_done), .fault(fault), .state(state)
  );

  logic [22:0] strobes;
  logic [W-1:0] obs;
  assign strobes = {PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, MDRin, Mem_Read,
                    Mem_enable512x32, MDRout, IRin, Grb, Grc, Gra, Rout, Rin, Yin, Cout,
                    HIout, LOout, HIin, LOin};
  assign obs = {state, strobes, opcode, instr_done, fault};

  localparam logic [22:0] M_PCOUT = 23'd1 << 22, M_INCPC = 23'd1 << 21, M_MARIN = 23'd1 << 20;
  localparam logic [22:0] M_ZIN = 23'd1 << 19, M_ZLO = 23'd1 << 18, M_ZHI = 23'd1 << 17;
  localparam logic [22:0] M_PCIN = 23'd1 << 16, M_MDRIN = 23'd1 << 15, M_MEMRD = 23'd1 << 14;
  localparam logic [22:0] M_MEMEN = 23'd1 << 13, M_MDROUT = 23'd1 << 12, M_IRIN = 23'd1 << 11;
  localparam logic [22:0] M_GRB = 23'd1 << 10, M_GRA = 23'd1 << 8;
  localparam logic [22:0] M_ROUT = 23'd1 << 7, M_RIN = 23'd1 << 6, M_YIN = 23'd1 << 5;
  localparam logic [22:0] M_COUT = 23'd1 << 4, M_HIOUT = 23'd1 << 3, M_LOOUT = 23'd1 << 2;
  localparam logic [22:0] M_HIIN = 23'd1 << 1, M_LOIN = 23'd1 << 0;

  logic [W-1:0] exp_q[$];
  logic [6:0]   stim_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] rir();
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic push(input state_t st, input logic [22:0] s, input logic [4:0] opc,
                      input logic done, input logic flt, input logic run_v,
                      input logic mr, input logic [4:0] ir);
    exp_q.push_back({4'(st), s, opc, done, flt});
    stim_q.push_back({run_v, mr, ir});
  endtask

  task automatic add_idle(input int n, input logic last_run);
    for (int i = 0; i < n; i++)
      push(IDLE, '0, '0, 1'b0, 1'b0, (i == n - 1) ? last_run : 1'b0, rb(), rir());
  endtask

  // One instruction as the sequence of cycles it should produce; run is random except where it matters.
  task automatic add_instr(input logic [4:0] op, input int lows, input logic run_after);
    logic [22:0] fetch;
    fetch = M_ZLO | M_MDRIN | M_MEMRD | M_MEMEN;
    push(T0, M_PCOUT | M_INCPC | M_MARIN | M_ZIN, '0, 1'b0, 1'b0, rb(), rb(), rir());
    if (lows >= 8) begin
      for (int i = 0; i < 8; i++)
        push(T1, fetch | ((i == 0) ? M_PCIN : 23'd0), '0, 1'b0, 1'b0, rb(), 1'b0, rir());
      for (int i = 0; i < 3; i++) push(HALT, '0, '0, 1'b0, 1'b1, rb(), rb(), rir());
      return;
    end
    for (int i = 0; i <= lows; i++)
      push(T1, fetch | ((i == 0) ? M_PCIN : 23'd0), '0, 1'b0, 1'b0, rb(), (i == lows), rir());
    push(T2, M_MDROUT | M_IRIN, '0, 1'b0, 1'b0, rb(), rb(), op);
    case (op)
      5'b00011, 5'b01011, 5'b01010: begin
        push(T3, M_GRB | M_ROUT | M_YIN, '0, 1'b0, 1'b0, rb(), rb(), rir());
        push(T4, M_COUT | M_ZIN, op, 1'b0, 1'b0, rb(), rb(), rir());
        push(T5, M_ZLO | M_GRA | M_RIN, '0, 1'b1, 1'b0, run_after, rb(), rir());
      end
      5'b10000:
        push(T3, M_HIOUT | M_GRA | M_RIN, '0, 1'b1, 1'b0, run_after, rb(), rir());
      5'b10001:
        push(T3, M_LOOUT | M_GRA | M_RIN, '0, 1'b1, 1'b0, run_after, rb(), rir());
      5'b01110, 5'b01111: begin
        push(T3, M_GRA | M_ROUT | M_YIN, '0, 1'b0, 1'b0, rb(), rb(), rir());
        push(T4, M_GRB | M_ROUT | M_ZIN, op, 1'b0, 1'b0, rb(), rb(), rir());
        push(T5, M_ZLO | M_LOIN, '0, 1'b0, 1'b0, rb(), rb(), rir());
        push(T6, M_ZHI | M_HIIN, '0, 1'b1, 1'b0, run_after, rb(), rir());
      end
      default: begin
        push(T3, '0, '0, 1'b0, 1'b0, rb(), rb(), rir());
        for (int i = 0; i < 3; i++) push(HALT, '0, '0, 1'b0, 1'b1, rb(), rb(), rir());
      end
    endcase
  endtask

  task automatic check_front(input string name);
    logic [W-1:0] e;
    logic [6:0]   s;
    e = exp_q.pop_front();
    s = stim_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%0d strb=%h opc=%h done=%b flt=%b, want st=%0d strb=%h opc=%h done=%b flt=%b",
               name, obs[33:30], obs[29:7], obs[6:2], obs[1], obs[0],
               e[33:30], e[29:7], e[6:2], e[1], e[0]);
    end
    n_checks++;
    if ($countones({PCout, Zlo_out, Zhi_out, MDRout, Rout, HIout, LOout, Cout}) > 1) begin
      n_fail++;
      $display("FAIL %s_bus_drivers: got %b, want at most one set", name,
               {PCout, Zlo_out, Zhi_out, MDRout, Rout, HIout, LOout, Cout});
    end
    {run, Mem_ready, IR_op} = s;
  endtask

  task automatic run_entries(input string name);
    while (exp_q.size() > 0) begin
      check_front(name);
      @(negedge Clock); #1;
    end
  endtask

  task automatic do_reset(input string name);
    exp_q.delete();
    stim_q.delete();
    clear = 1'b0; run = 1'b0; Mem_ready = 1'b0; IR_op = '0;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL %s_async: got %h, want all zero (IDLE)", name, obs);
    end
    @(negedge Clock); #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL %s_held: got %h, want all zero (IDLE)", name, obs);
    end
    clear = 1'b1;
  endtask

  task automatic test_reset();
    do_reset("reset");
    add_idle(3, 1'b0);
    run_entries("reset_idle");
  endtask

  task automatic test_imm_back_to_back();
    add_idle(1, 1'b1);
    add_instr(5'b00011, 0, 1'b1);
    add_instr(5'b01011, 0, 1'b1);
    add_instr(5'b01010, 0, 1'b0);
    add_idle(2, 1'b0);
    run_entries("imm");
  endtask

  task automatic test_move();
    add_idle(1, 1'b1);
    add_instr(5'b10001, 0, 1'b1);
    add_instr(5'b10000, 0, 1'b0);
    add_idle(1, 1'b0);
    run_entries("move");
  endtask

  task automatic test_muldiv();
    add_idle(1, 1'b1);
    add_instr(5'b01110, 0, 1'b1);
    add_instr(5'b01111, 0, 1'b0);
    add_idle(1, 1'b0);
    run_entries("muldiv");
  endtask

  task automatic test_mem_wait();
    add_idle(1, 1'b1);
    add_instr(5'b00011, 3, 1'b1);
    add_instr(5'b01110, 7, 1'b0);
    add_idle(1, 1'b0);
    run_entries("mem_wait");
  endtask

  task automatic test_random();
    logic [4:0] legal[7];
    logic ra;
    legal = '{5'b00011, 5'b01011, 5'b01010, 5'b10000, 5'b10001, 5'b01110, 5'b01111};
    add_idle(1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      ra = (i == 29) ? 1'b0 : rb();
      add_instr(legal[$urandom_range(0, 6)], $urandom_range(0, 7), ra);
      if (!ra) add_idle($urandom_range(1, 3), i != 29);
    end
    run_entries("random");
  endtask

  task automatic test_timeout();
    add_idle(1, 1'b1);
    add_instr(5'b00011, 8, 1'b1);
    run_entries("timeout");
    do_reset("timeout_clear");
  endtask

  task automatic test_illegal();
    logic [4:0] op;
    add_idle(1, 1'b1);
    add_instr(5'b11111, 0, 1'b0);
    run_entries("illegal");
    do_reset("illegal_clear");
    for (int k = 0; k < 4; k++) begin
      do begin
        op = rir();
      end while (op == 5'b00011 || op == 5'b01011 || op == 5'b01010 || op == 5'b10000 ||
                 op == 5'b10001 || op == 5'b01110 || op == 5'b01111);
      add_idle(1, 1'b1);
      add_instr(op, $urandom_range(0, 5), 1'b0);
      run_entries("illegal_rand");
      do_reset("illegal_rand_clear");
    end
  endtask

  task automatic test_clear_mid();
    add_idle(1, 1'b1);
    add_instr(5'b01110, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_front("clear_mid");
      @(negedge Clock); #1;
    end
    check_front("clear_mid_t4");
    do_reset("clear_mid");
    add_idle(1, 1'b1);
    add_instr(5'b01010, 2, 1'b0);
    add_idle(1, 1'b0);
    run_entries("after_clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0; run = 1'b0; Mem_ready = 1'b0; IR_op = '0;
    @(negedge Clock); #1;
    test_reset();
    test_imm_back_to_back();
    test_move();
    test_muldiv();
    test_mem_wait();
    test_random();
    test_timeout();
    test_illegal();
    test_clear_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
